// File: rtl/i2s_rx.sv
// I2S receiver: oversamples BCLK/LRCLK/SDATA on clk and deserialises signed left/right samples.
// Optional macro I2S_RX_MONO_MIX_EN makes dout the halved sum of both channels instead of left.
module i2s_rx #(
  parameter int AUDIO_DW = 16,
  parameter int SLOT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i2s_bclk,
  input  logic                       i2s_lrclk,
  input  logic                       i2s_sdata,
  output logic signed [AUDIO_DW-1:0] left,
  output logic signed [AUDIO_DW-1:0] right,
  output logic                       valid,
  output logic signed [AUDIO_DW-1:0] dout
);

  localparam int                  CNT_W   = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(SLOT_W - 1);
  localparam logic [AUDIO_DW-1:0] MSB_BIT = AUDIO_DW'(1) << (AUDIO_DW - 1);

  typedef enum logic {
    WAIT_SYNC,
    RUN
  } state_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

`ifdef I2S_RX_MONO_MIX_EN
  // Sum in one extra bit, then drop the LSB: arithmetic halve, truncating.
  function automatic logic signed [AUDIO_DW-1:0] mono_mix(
    input logic signed [AUDIO_DW-1:0] a,
    input logic signed [AUDIO_DW-1:0] b
  );
    logic signed [AUDIO_DW:0] sum;
    sum = {a[AUDIO_DW-1], a} + {b[AUDIO_DW-1], b};
    return sum[AUDIO_DW:1];
  endfunction
`endif

  logic bclk_meta_p0, bclk_p0, bclk_dly_p0;
  logic lrclk_meta_p0, lrclk_p0;
  logic sdata_meta_p0, sdata_p0;

  logic vld_p1, lrclk_p1, sdata_p1;

  state_t                       state;
  logic                         lrclk_prev;
  logic [AUDIO_DW-1:0]          shreg;
  logic [CNT_W-1:0]             cnt;
  logic signed [AUDIO_DW-1:0]   word_p1;
  logic                         boundary_p1;

  // Stage p0: two-flop synchronisers plus one delayed BCLK for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_meta_p0  <= 1'b0;
      bclk_p0       <= 1'b0;
      bclk_dly_p0   <= 1'b0;
      lrclk_meta_p0 <= 1'b0;
      lrclk_p0      <= 1'b0;
      sdata_meta_p0 <= 1'b0;
      sdata_p0      <= 1'b0;
    end else begin
      bclk_meta_p0  <= i2s_bclk;
      bclk_p0       <= bclk_meta_p0;
      bclk_dly_p0   <= bclk_p0;
      lrclk_meta_p0 <= i2s_lrclk;
      lrclk_p0      <= lrclk_meta_p0;
      sdata_meta_p0 <= i2s_sdata;
      sdata_p0      <= sdata_meta_p0;
    end
  end

  // Stage p1: registered BCLK rise with the LRCLK/SDATA values seen on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      lrclk_p1 <= 1'b0;
      sdata_p1 <= 1'b0;
    end else begin
      vld_p1   <= bclk_p0 & ~bclk_dly_p0;
      lrclk_p1 <= lrclk_p0;
      sdata_p1 <= sdata_p0;
    end
  end

  // The mask shifts out to zero once cnt reaches AUDIO_DW, which truncates long slots.
  always_comb begin
    word_p1     = shreg | (sdata_p1 ? (MSB_BIT >> cnt) : '0);
    boundary_p1 = lrclk_p1 ^ lrclk_prev;
  end

  // Stage p2: capture, word commit and sync state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SYNC;
      lrclk_prev <= 1'b0;
      shreg      <= '0;
      cnt        <= '0;
      left       <= '0;
      right      <= '0;
      dout       <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (vld_p1) begin
        lrclk_prev <= lrclk_p1;
        if (boundary_p1) begin
          shreg <= '0;
          cnt   <= '0;
          case (state)
            WAIT_SYNC: begin
              if (lrclk_prev) state <= RUN;
            end
            RUN: begin
              if (!lrclk_prev) begin
                left <= word_p1;
              end else begin
                right <= word_p1;
`ifdef I2S_RX_MONO_MIX_EN
                dout  <= mono_mix(left, word_p1);
`else
                dout  <= left;
`endif
                valid <= 1'b1;
              end
            end
            default: state <= WAIT_SYNC;
          endcase
        end else begin
          shreg <= word_p1;
          cnt   <= cnt_sat_inc(cnt);
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: drives I2S frames and compares each valid pulse against a model.
module tb_i2s_rx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          bclk = 1'b0;
  logic          lr = 1'b0;
  logic          sd = 1'b0;
  logic [DW-1:0] left, right, dout;
  logic          valid;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  logic carry = 1'b0;
  int   checks = 0;
  int   failures = 0;

  i2s_rx #(.AUDIO_DW(DW), .SLOT_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i2s_bclk  (bclk),
    .i2s_lrclk (lr),
    .i2s_sdata (sd),
    .left      (left),
    .right     (right),
    .valid     (valid),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Left-justify an s-bit slot word, keep the top DW bits.
  function automatic logic [DW-1:0] lj(input logic [31:0] w, input int s);
    logic [31:0] t;
    t = w << (32 - s);
    return t[31:32-DW];
  endfunction

  function automatic exp_t model(input logic [31:0] l, input logic [31:0] r, input int s);
    exp_t e;
    int   a, b, m;
    e.l = lj(l, s);
    e.r = lj(r, s);
`ifdef I2S_RX_MONO_MIX_EN
    a = int'($signed(e.l));
    b = int'($signed(e.r));
    m = (a + b) >>> 1;
    e.d = m[DW-1:0];
`else
    a = 0; b = 0; m = 0;
    e.d = e.l;
`endif
    return e;
  endfunction

  // One BCLK period: low phase with new LRCLK/SDATA, returns right after the rising edge.
  task automatic bit_rise(input logic l, input logic d);
    repeat (3) @(negedge clk);
    bclk = 1'b0;
    lr   = l;
    sd   = d;
    repeat (3) @(negedge clk);
    bclk = 1'b1;
  endtask

  // One-BCLK I2S delay: first bit of a slot is the LSB of the previous one.
  task automatic send_slot(input logic l, input logic [31:0] w, input int s);
    for (int i = 0; i < s; i++) bit_rise(l, (i == 0) ? carry : w[s-i]);
    carry = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int s,
                            input bit push);
    send_slot(1'b0, l, s);
    send_slot(1'b1, r, s);
    if (push) begin
      last_exp = model(l, r, s);
      sb.push_back(last_exp);
    end
  endtask

  task automatic close_frame();
    bit_rise(1'b0, carry);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bclk  = 1'b0;
    lr    = 1'b0;
    sd    = 1'b0;
    carry = 1'b0;
    #1;
    chk("rst_left", left, 0);
    chk("rst_right", right, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("left", left, e.l);
          chk("right", right, e.r);
          chk("dout", dout, e.d);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Basic 32-bit frames, first frame after reset discarded, latency check on the close.
    reset_dut();
    send_frame(32'h12340000, 32'hFEDC0000, 32, 1'b0);
    send_frame(32'h12340000, 32'hFEDC0000, 32, 1'b1);
    close_frame();
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_valid_%0d", k), valid, (k == 4) ? 1 : 0);
    end
    repeat (4) @(negedge clk);

    // 24-bit slots: truncation.
    reset_dut();
    send_frame(32'h00ABCDEF, 32'h00012345, 24, 1'b0);
    send_frame(32'h00ABCDEF, 32'h00012345, 24, 1'b1);
    send_frame(32'h00800001, 32'h007FFFFE, 24, 1'b1);
    close_frame();
    repeat (8) @(negedge clk);

    // 8-bit slots: zero-fill.
    reset_dut();
    send_frame(32'h000000A5, 32'h0000003C, 8, 1'b0);
    send_frame(32'h000000A5, 32'h0000003C, 8, 1'b1);
    send_frame(32'h0000005A, 32'h000000C3, 8, 1'b1);
    close_frame();
    repeat (8) @(negedge clk);

    // Reset asserted mid-right-slot during steady traffic.
    reset_dut();
    send_frame(32'h0F0F0000, 32'hF0F00000, 32, 1'b0);
    send_frame(32'h11110000, 32'h22220000, 32, 1'b1);
    send_slot(1'b0, 32'h55550000, 32);
    for (int i = 0; i < 10; i++) bit_rise(1'b1, i[0]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_left", left, 0);
    chk("midrst_right", right, 0);
    chk("midrst_dout", dout, 0);
    chk("midrst_valid", valid, 0);
    bclk = 1'b0;
    carry = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_frame(32'h99990000, 32'hAAAA0000, 32, 1'b0);
    send_frame(32'h66660000, 32'h77770000, 32, 1'b1);
    close_frame();
    repeat (8) @(negedge clk);

    // Mono-mix corner values, then a one-sided signal.
    reset_dut();
    send_frame(32'h00000000, 32'h00000000, 16, 1'b0);
    send_frame(32'h00007FFF, 32'h00007FFF, 16, 1'b1);
    send_frame(32'h00008000, 32'h00007FFF, 16, 1'b1);
    send_frame(32'h00000000, 32'h00001234, 16, 1'b1);
    close_frame();

    // LRCLK stops for over 1000 clk: no strobes, outputs hold.
    for (int i = 0; i < 170; i++) bit_rise(1'b0, i[1]);
    chk("hold_left", left, last_exp.l);
    chk("hold_right", right, last_exp.r);
    chk("hold_dout", dout, last_exp.d);
    chk("hold_valid", valid, 0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
